// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port between the ICache and DCache
// refill engines. One single-beat 128-bit transaction is in flight at a time;
// simultaneous requests are resolved round-robin.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // ICache refill interface
    input  logic                      icache_rd_req,
    input  logic [ADDR_WIDTH-1:0]     icache_rd_addr,
    output logic                      icache_rd_accept,
    output logic                      icache_rd_valid,
    output logic [AXI_DATA_WIDTH-1:0] icache_rd_data,
    output logic                      icache_rd_err,
    // DCache refill interface
    input  logic                      dcache_rd_req,
    input  logic [ADDR_WIDTH-1:0]     dcache_rd_addr,
    output logic                      dcache_rd_accept,
    output logic                      dcache_rd_valid,
    output logic [AXI_DATA_WIDTH-1:0] dcache_rd_data,
    output logic                      dcache_rd_err,
    // AXI4 read address channel
    output logic [AXI_ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    // AXI4 read data channel
    input  logic [AXI_ID_WIDTH-1:0]   rid,
    input  logic [AXI_DATA_WIDTH-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    localparam logic                    SRC_ICACHE = 1'b0;
    localparam logic                    SRC_DCACHE = 1'b1;
    localparam logic [AXI_ID_WIDTH-1:0] ID_ICACHE  = '0;
    localparam logic [AXI_ID_WIDTH-1:0] ID_DCACHE  = AXI_ID_WIDTH'(1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_last;
    logic                      r_gnt;
    logic [ADDR_WIDTH-1:0]     r_araddr;
    logic [AXI_ID_WIDTH-1:0]   r_arid;
    logic                      r_ic_valid;
    logic [AXI_DATA_WIDTH-1:0] r_ic_data;
    logic                      r_ic_err;
    logic                      r_dc_valid;
    logic [AXI_DATA_WIDTH-1:0] r_dc_data;
    logic                      r_dc_err;

    logic w_win_d;
    logic w_grant;
    logic w_r_done;
    logic w_ic_acc;
    logic w_dc_acc;
    logic w_arvalid;
    logic w_rready;
    logic w_unused;

    // DCache wins when it is alone, or on a tie when ICache was served last
    assign w_win_d  = dcache_rd_req && (!icache_rd_req || (r_last == SRC_ICACHE));
    assign w_grant  = (r_state == IDLE) && (icache_rd_req || dcache_rd_req);
    // Only the single beat carrying our ID and RLAST completes the refill
    assign w_r_done = (r_state == R) && rvalid && rlast && (rid == r_arid);
    // Only the error bit of RRESP is forwarded
    assign w_unused = rresp[0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_ic_acc     = 1'b0;
        w_dc_acc     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (icache_rd_req || dcache_rd_req) begin
                    w_next_state = AR;
                    if (w_win_d) begin
                        w_dc_acc = 1'b1;
                    end else begin
                        w_ic_acc = 1'b1;
                    end
                end
            end
            AR: begin
                w_arvalid = 1'b1;
                if (arready) begin
                    w_next_state = R;
                end
            end
            R: begin
                w_rready = 1'b1;
                if (w_r_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Capture the winner's address, ID and identity at grant time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr <= '0;
            r_arid   <= '0;
            r_gnt    <= SRC_ICACHE;
            r_last   <= SRC_ICACHE;
        end else if (w_grant) begin
            r_araddr <= w_win_d ? dcache_rd_addr : icache_rd_addr;
            r_arid   <= w_win_d ? ID_DCACHE : ID_ICACHE;
            r_gnt    <= w_win_d ? SRC_DCACHE : SRC_ICACHE;
            r_last   <= w_win_d ? SRC_DCACHE : SRC_ICACHE;
        end
    end

    // Route the completing beat to the granted cache; data holds between refills
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ic_valid <= 1'b0;
            r_ic_data  <= '0;
            r_ic_err   <= 1'b0;
            r_dc_valid <= 1'b0;
            r_dc_data  <= '0;
            r_dc_err   <= 1'b0;
        end else begin
            r_ic_valid <= w_r_done && (r_gnt == SRC_ICACHE);
            r_dc_valid <= w_r_done && (r_gnt == SRC_DCACHE);
            if (w_r_done && (r_gnt == SRC_ICACHE)) begin
                r_ic_data <= rdata;
                r_ic_err  <= rresp[1];
            end
            if (w_r_done && (r_gnt == SRC_DCACHE)) begin
                r_dc_data <= rdata;
                r_dc_err  <= rresp[1];
            end
        end
    end

    assign icache_rd_accept = w_ic_acc;
    assign dcache_rd_accept = w_dc_acc;
    assign icache_rd_valid  = r_ic_valid;
    assign icache_rd_data   = r_ic_data;
    assign icache_rd_err    = r_ic_err;
    assign dcache_rd_valid  = r_dc_valid;
    assign dcache_rd_data   = r_dc_data;
    assign dcache_rd_err    = r_dc_err;

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = 8'd0;
    assign arsize  = 3'b100;
    assign arburst = 2'b01;
    assign arvalid = w_arvalid;
    assign rready  = w_rready;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          icache_rd_req;
    logic [AW-1:0] icache_rd_addr;
    logic          icache_rd_accept;
    logic          icache_rd_valid;
    logic [DW-1:0] icache_rd_data;
    logic          icache_rd_err;
    logic          dcache_rd_req;
    logic [AW-1:0] dcache_rd_addr;
    logic          dcache_rd_accept;
    logic          dcache_rd_valid;
    logic [DW-1:0] dcache_rd_data;
    logic          dcache_rd_err;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    int checks = 0;
    int errors = 0;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
        .icache_rd_accept(icache_rd_accept), .icache_rd_valid(icache_rd_valid),
        .icache_rd_data(icache_rd_data), .icache_rd_err(icache_rd_err),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_accept(dcache_rd_accept), .dcache_rd_valid(dcache_rd_valid),
        .dcache_rd_data(dcache_rd_data), .dcache_rd_err(dcache_rd_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_idle();
        rvalid = 1'b0; rlast = 1'b0; rid = '0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0b want 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %0b want 0", rready); end
        checks++; if (araddr !== '0 || arid !== '0) begin errors++; $display("FAIL reset_araddr_arid: got %h/%0d want 0/0", araddr, arid); end
        checks++; if ({icache_rd_valid, dcache_rd_valid, icache_rd_err, dcache_rd_err} !== 4'b0) begin errors++; $display("FAIL reset_valid_err: got %b want 0000", {icache_rd_valid, dcache_rd_valid, icache_rd_err, dcache_rd_err}); end
        checks++; if (icache_rd_data !== '0 || dcache_rd_data !== '0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", icache_rd_data, dcache_rd_data); end
        checks++; if ({icache_rd_accept, dcache_rd_accept} !== 2'b00) begin errors++; $display("FAIL reset_accept: got %b want 00", {icache_rd_accept, dcache_rd_accept}); end
    endtask

    task automatic test_icache_only();
        logic [DW-1:0] d;
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        // cycle 0
        icache_rd_req = 1'b1; icache_rd_addr = 32'h1C00_0000;
        #2;
        checks++; if (icache_rd_accept !== 1'b1) begin errors++; $display("FAIL ic_only_accept: got %0b want 1", icache_rd_accept); end
        checks++; if (dcache_rd_accept !== 1'b0) begin errors++; $display("FAIL ic_only_dc_accept: got %0b want 0", dcache_rd_accept); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL ic_only_arvalid_c0: got %0b want 0", arvalid); end
        // cycle 1
        step(); icache_rd_req = 1'b0; arready = 1'b1;
        #2;
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL ic_only_arvalid_c1: got %0b want 1", arvalid); end
        checks++; if (araddr !== 32'h1C00_0000) begin errors++; $display("FAIL ic_only_araddr: got %h want 1c000000", araddr); end
        checks++; if (arid !== 4'd0) begin errors++; $display("FAIL ic_only_arid: got %0d want 0", arid); end
        checks++; if (arlen !== 8'd0 || arsize !== 3'd4 || arburst !== 2'b01) begin errors++; $display("FAIL ic_only_arconst: got %0d/%0d/%0d want 0/4/1", arlen, arsize, arburst); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL ic_only_rready_c1: got %0b want 0", rready); end
        // cycle 2
        step(); arready = 1'b0;
        #2;
        checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL ic_only_c2: got rready=%0b arvalid=%0b want 1/0", rready, arvalid); end
        // cycle 3
        step(); rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = d; rresp = 2'b00;
        #2;
        checks++; if (icache_rd_valid !== 1'b0) begin errors++; $display("FAIL ic_only_valid_c3: got %0b want 0", icache_rd_valid); end
        // cycle 4
        step(); r_idle();
        #2;
        checks++; if (icache_rd_valid !== 1'b1) begin errors++; $display("FAIL ic_only_valid_c4: got %0b want 1", icache_rd_valid); end
        checks++; if (icache_rd_data !== d) begin errors++; $display("FAIL ic_only_data: got %h want %h", icache_rd_data, d); end
        checks++; if (icache_rd_err !== 1'b0 || dcache_rd_valid !== 1'b0) begin errors++; $display("FAIL ic_only_err_dvalid: got %0b/%0b want 0/0", icache_rd_err, dcache_rd_valid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL ic_only_rready_c4: got %0b want 0", rready); end
        // cycle 5: pulse ends, data holds
        step();
        #2;
        checks++; if (icache_rd_valid !== 1'b0 || icache_rd_data !== d) begin errors++; $display("FAIL ic_only_hold: got valid=%0b data=%h want 0/%h", icache_rd_valid, icache_rd_data, d); end
    endtask

    task automatic test_tie();
        // fresh reset so last granted is ICache
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_1000;
        dcache_rd_req = 1'b1; dcache_rd_addr = 32'h0000_2000;
        #2;
        checks++; if ({icache_rd_accept, dcache_rd_accept} !== 2'b01) begin errors++; $display("FAIL tie1_accept: got ic/dc=%b want 01", {icache_rd_accept, dcache_rd_accept}); end
        step(); dcache_rd_req = 1'b0; arready = 1'b1;
        #2;
        checks++; if (arid !== 4'd1 || araddr !== 32'h0000_2000) begin errors++; $display("FAIL tie1_ar: got arid=%0d araddr=%h want 1/00002000", arid, araddr); end
        checks++; if (icache_rd_accept !== 1'b0) begin errors++; $display("FAIL tie1_no_accept_ar: got %0b want 0", icache_rd_accept); end
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 128'hD1; rresp = 2'b00;
        #2;
        checks++; if (icache_rd_accept !== 1'b0) begin errors++; $display("FAIL tie1_no_accept_r: got %0b want 0", icache_rd_accept); end
        // response completes: ICache accepted in same cycle, DCache re-requests (tie)
        step(); r_idle(); dcache_rd_req = 1'b1;
        #2;
        checks++; if (dcache_rd_valid !== 1'b1 || dcache_rd_data !== 128'hD1) begin errors++; $display("FAIL tie1_dvalid: got %0b/%h want 1/d1", dcache_rd_valid, dcache_rd_data); end
        checks++; if ({icache_rd_accept, dcache_rd_accept} !== 2'b10) begin errors++; $display("FAIL tie2_accept: got ic/dc=%b want 10", {icache_rd_accept, dcache_rd_accept}); end
        step(); icache_rd_req = 1'b0; arready = 1'b1;
        #2;
        checks++; if (arid !== 4'd0 || araddr !== 32'h0000_1000) begin errors++; $display("FAIL tie2_ar: got arid=%0d araddr=%h want 0/00001000", arid, araddr); end
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 128'hC2;
        step(); r_idle(); icache_rd_req = 1'b1;
        #2;
        checks++; if (icache_rd_valid !== 1'b1 || icache_rd_data !== 128'hC2) begin errors++; $display("FAIL tie2_ivalid: got %0b/%h want 1/c2", icache_rd_valid, icache_rd_data); end
        checks++; if ({icache_rd_accept, dcache_rd_accept} !== 2'b01) begin errors++; $display("FAIL tie3_accept: got ic/dc=%b want 01", {icache_rd_accept, dcache_rd_accept}); end
        step(); icache_rd_req = 1'b0; dcache_rd_req = 1'b0; arready = 1'b1;
        #2;
        checks++; if (arid !== 4'd1) begin errors++; $display("FAIL tie3_arid: got %0d want 1", arid); end
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 128'hD3;
        step(); r_idle();
        #2;
        checks++; if (dcache_rd_valid !== 1'b1 || dcache_rd_data !== 128'hD3) begin errors++; $display("FAIL tie3_dvalid: got %0b/%h want 1/d3", dcache_rd_valid, dcache_rd_data); end
        step();
    endtask

    task automatic test_ar_backpressure();
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_3000;
        #2;
        checks++; if (icache_rd_accept !== 1'b1) begin errors++; $display("FAIL bp_accept: got %0b want 1", icache_rd_accept); end
        step(); icache_rd_req = 1'b0; dcache_rd_req = 1'b1; dcache_rd_addr = 32'h0000_3800; arready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) arready = 1'b1;
            #2;
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h0000_3000 || arid !== 4'd0) begin errors++; $display("FAIL bp_stable[%0d]: got v=%0b a=%h id=%0d want 1/00003000/0", i, arvalid, araddr, arid); end
            checks++; if ({icache_rd_accept, dcache_rd_accept} !== 2'b00) begin errors++; $display("FAIL bp_no_accept[%0d]: got %b want 00", i, {icache_rd_accept, dcache_rd_accept}); end
            step();
        end
        arready = 1'b0;
        #2;
        checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL bp_in_r: got rready=%0b arvalid=%0b want 1/0", rready, arvalid); end
        rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 128'hB0;
        step(); r_idle();
        #2;
        checks++; if (icache_rd_valid !== 1'b1 || dcache_rd_accept !== 1'b1) begin errors++; $display("FAIL bp_done: got ivalid=%0b dacc=%0b want 1/1", icache_rd_valid, dcache_rd_accept); end
        step(); dcache_rd_req = 1'b0; arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 128'hB1;
        step(); r_idle();
        #2;
        checks++; if (dcache_rd_valid !== 1'b1 || dcache_rd_data !== 128'hB1) begin errors++; $display("FAIL bp_dvalid: got %0b/%h want 1/b1", dcache_rd_valid, dcache_rd_data); end
        step();
    endtask

    task automatic test_mismatched_rid();
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_4000;
        step(); icache_rd_req = 1'b0; arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd2; rdata = 128'hBAD;
        #2;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rid_bogus_rready: got %0b want 1", rready); end
        step(); rlast = 1'b0; rid = 4'd0; rdata = 128'hBAD2;
        #2;
        checks++; if ({icache_rd_valid, dcache_rd_valid} !== 2'b00 || rready !== 1'b1) begin errors++; $display("FAIL rid_bogus_drop: got valids=%b rready=%0b want 00/1", {icache_rd_valid, dcache_rd_valid}, rready); end
        step(); rlast = 1'b1; rdata = 128'h600D;
        #2;
        checks++; if ({icache_rd_valid, dcache_rd_valid} !== 2'b00 || rready !== 1'b1) begin errors++; $display("FAIL rid_nolast_drop: got valids=%b rready=%0b want 00/1", {icache_rd_valid, dcache_rd_valid}, rready); end
        step(); r_idle();
        #2;
        checks++; if (icache_rd_valid !== 1'b1 || icache_rd_data !== 128'h600D || icache_rd_err !== 1'b0) begin errors++; $display("FAIL rid_good: got %0b/%h/%0b want 1/600d/0", icache_rd_valid, icache_rd_data, icache_rd_err); end
        step();
    endtask

    task automatic test_error_resp();
        dcache_rd_req = 1'b1; dcache_rd_addr = 32'h0000_5000;
        #2;
        checks++; if (dcache_rd_accept !== 1'b1) begin errors++; $display("FAIL err_accept: got %0b want 1", dcache_rd_accept); end
        step(); dcache_rd_req = 1'b0; arready = 1'b1;
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rresp = 2'b10; rdata = 128'hE0;
        step(); r_idle();
        #2;
        checks++; if (dcache_rd_valid !== 1'b1 || dcache_rd_err !== 1'b1) begin errors++; $display("FAIL err_flag: got valid=%0b err=%0b want 1/1", dcache_rd_valid, dcache_rd_err); end
        checks++; if (dcache_rd_data !== 128'hE0 || icache_rd_valid !== 1'b0) begin errors++; $display("FAIL err_data: got %h ivalid=%0b want e0/0", dcache_rd_data, icache_rd_valid); end
        step();
    endtask

    task automatic test_reset_mid_r();
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_6000;
        step(); icache_rd_req = 1'b0; arready = 1'b1;
        step(); arready = 1'b0;
        #2;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rst_r_reached: got %0b want 1", rready); end
        rst_n = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 128'h57A1E;
        #1;
        checks++; if ({rready, arvalid} !== 2'b00 || araddr !== '0 || arid !== '0) begin errors++; $display("FAIL rst_r_outputs: got rr/av=%b a=%h id=%0d want 00/0/0", {rready, arvalid}, araddr, arid); end
        checks++; if (icache_rd_data !== '0 || dcache_rd_data !== '0 || {icache_rd_err, dcache_rd_err} !== 2'b00) begin errors++; $display("FAIL rst_r_data: got %h/%h want 0/0", icache_rd_data, dcache_rd_data); end
        step(); rst_n = 1'b1;
        step(); r_idle();
        #2;
        checks++; if ({icache_rd_valid, dcache_rd_valid, rready} !== 3'b000) begin errors++; $display("FAIL rst_r_no_stale: got %b want 000", {icache_rd_valid, dcache_rd_valid, rready}); end
        icache_rd_req = 1'b1; icache_rd_addr = 32'h0000_7000;
        #1;
        checks++; if (icache_rd_accept !== 1'b1) begin errors++; $display("FAIL rst_r_new_accept: got %0b want 1", icache_rd_accept); end
        step(); icache_rd_req = 1'b0; arready = 1'b1;
        #2;
        checks++; if (araddr !== 32'h0000_7000 || arid !== 4'd0) begin errors++; $display("FAIL rst_r_new_ar: got %h/%0d want 00007000/0", araddr, arid); end
        step(); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 128'h7777;
        step(); r_idle();
        #2;
        checks++; if (icache_rd_valid !== 1'b1 || icache_rd_data !== 128'h7777) begin errors++; $display("FAIL rst_r_new_data: got %0b/%h want 1/7777", icache_rd_valid, icache_rd_data); end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        icache_rd_req = 1'b0; icache_rd_addr = '0;
        dcache_rd_req = 1'b0; dcache_rd_addr = '0;
        arready = 1'b0; rdata = '0;
        r_idle();
        step();
        test_reset();
        step(); rst_n = 1'b1;
        step();
        test_icache_only();
        test_tie();
        test_ar_backpressure();
        test_mismatched_rid();
        test_error_resp();
        test_reset_mid_r();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
